// File: rtl/fifo_access_scheduler_if.sv
// Requester and FIFO-side signal bundle for fifo_access_scheduler.
// The slave side is the scheduler; the master side drives requests and FIFO responses.
interface fifo_access_scheduler_if #(
    parameter int NUM_WR = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [NUM_WR-1:0]       wr_req;
    logic [NUM_WR*WIDTH-1:0] wr_data;
    logic [NUM_WR-1:0]       wr_gnt;
    logic                    rd_req;
    logic                    rd_gnt;
    logic [WIDTH-1:0]        rd_data;
    logic                    rd_valid;
    logic                    fifo_en;
    logic                    fifo_mode;
    logic [WIDTH-1:0]        fifo_din;
    logic [WIDTH-1:0]        fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [OCC_W-1:0]        occupancy;

    modport master (
        output wr_req, wr_data, rd_req, fifo_dout, fifo_full, fifo_empty,
        input  wr_gnt, rd_gnt, rd_data, rd_valid, fifo_en, fifo_mode, fifo_din, occupancy
    );

    modport slave (
        input  wr_req, wr_data, rd_req, fifo_dout, fifo_full, fifo_empty,
        output wr_gnt, rd_gnt, rd_data, rd_valid, fifo_en, fifo_mode, fifo_din, occupancy
    );
endinterface

// File: rtl/fifo_access_scheduler.sv
// Arbitrates NUM_WR writers (round-robin) and one reader (alternating with writes)
// onto a single-port-style synchronous FIFO, returning read data with a valid pulse.
module fifo_access_scheduler #(
    parameter int NUM_WR = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16
) (
    input  logic                  clock,
    input  logic                  rst,
    fifo_access_scheduler_if.slave bus
);
    localparam int PTR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RD_CAP} state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic              last_op_rd_reg, last_op_rd_next;
    logic [OCC_W-1:0]  occ_reg, occ_next;
    logic [NUM_WR-1:0] wr_gnt_reg, wr_gnt_next;
    logic [WIDTH-1:0]  din_reg, din_next;
    logic              mode_reg, mode_next;
    logic [WIDTH-1:0]  rd_data_reg, rd_data_next;
    logic              rd_valid_reg, rd_valid_next;

    logic [WIDTH-1:0]  wr_data_arr [NUM_WR];
    logic [NUM_WR-1:0] wr_elig;
    logic              rd_elig;
    logic [PTR_W-1:0]  sel;
    logic              sel_found;
    logic [PTR_W-1:0]  sel_inc;

    generate
        for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_lane
            assign wr_data_arr[gi] = bus.wr_data[gi*WIDTH +: WIDTH];
            assign wr_elig[gi]     = bus.wr_req[gi] & ~bus.fifo_full;
        end
    endgenerate

    assign rd_elig = bus.rd_req & ~bus.fifo_empty;

    // Scan offsets from the farthest down to 0 so the nearest eligible index to rr_ptr wins.
    always_comb begin
        logic [PTR_W:0] sum;
        sel       = '0;
        sel_found = 1'b0;
        sum       = '0;
        for (int k = NUM_WR - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_WR)) begin
                sum = sum - (PTR_W+1)'(NUM_WR);
            end
            if (wr_elig[sum[PTR_W-1:0]]) begin
                sel       = sum[PTR_W-1:0];
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        logic [PTR_W:0] inc;
        inc = {1'b0, sel} + (PTR_W+1)'(1);
        if (inc == (PTR_W+1)'(NUM_WR)) begin
            inc = '0;
        end
        sel_inc = inc[PTR_W-1:0];
    end

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        last_op_rd_next = last_op_rd_reg;
        occ_next        = occ_reg;
        wr_gnt_next     = '0;
        din_next        = din_reg;
        mode_next       = mode_reg;
        rd_data_next    = rd_data_reg;
        rd_valid_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                // When both sides are eligible, the side not served last goes first.
                if (sel_found && (!rd_elig || last_op_rd_reg)) begin
                    state_next  = WRITE;
                    wr_gnt_next = NUM_WR'(1) << sel;
                    din_next    = wr_data_arr[sel];
                    mode_next   = 1'b0;
                    rr_ptr_next = sel_inc;
                end else if (rd_elig) begin
                    state_next = READ;
                    mode_next  = 1'b1;
                end
            end
            WRITE: begin
                last_op_rd_next = 1'b0;
                if (occ_reg != OCC_W'(DEPTH)) begin
                    occ_next = occ_reg + OCC_W'(1);
                end
                state_next = IDLE;
            end
            READ: begin
                last_op_rd_next = 1'b1;
                if (occ_reg != '0) begin
                    occ_next = occ_reg - OCC_W'(1);
                end
                state_next = RD_CAP;
            end
            RD_CAP: begin
                rd_data_next  = bus.fifo_dout;
                rd_valid_next = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            last_op_rd_reg <= 1'b1;
            occ_reg        <= '0;
            wr_gnt_reg     <= '0;
            din_reg        <= '0;
            mode_reg       <= 1'b0;
            rd_data_reg    <= '0;
            rd_valid_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            last_op_rd_reg <= last_op_rd_next;
            occ_reg        <= occ_next;
            wr_gnt_reg     <= wr_gnt_next;
            din_reg        <= din_next;
            mode_reg       <= mode_next;
            rd_data_reg    <= rd_data_next;
            rd_valid_reg   <= rd_valid_next;
        end
    end

    assign bus.fifo_en   = (state_reg == WRITE) || (state_reg == READ);
    assign bus.fifo_mode = mode_reg;
    assign bus.fifo_din  = din_reg;
    assign bus.wr_gnt    = wr_gnt_reg;
    assign bus.rd_gnt    = (state_reg == READ);
    assign bus.rd_data   = rd_data_reg;
    assign bus.rd_valid  = rd_valid_reg;
    assign bus.occupancy = occ_reg;
endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Directed bench for fifo_access_scheduler with a behavioural FIFO and a queue-based
// scoreboard: stimulus pushes expected grants/read data, a negedge monitor pops and compares.
module tb_fifo_access_scheduler;
    localparam int NW = 4;
    localparam int W  = 8;
    localparam int D  = 16;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    fifo_access_scheduler_if #(.NUM_WR(NW), .WIDTH(W), .DEPTH(D)) bus ();

    fifo_access_scheduler #(.NUM_WR(NW), .WIDTH(W), .DEPTH(D)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NW-1:0] gnt;
        logic [W-1:0]  din;
    } wexp_t;

    wexp_t        exp_wr [$];
    logic [W-1:0] exp_rd [$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Behavioural FIFO: registered read data, flags from its own count.
    logic [W-1:0] fmem [$];
    int           fcount = 0;
    logic [W-1:0] fdout  = '0;
    logic [W-1:0] ftmp;

    assign bus.fifo_full  = (fcount == D);
    assign bus.fifo_empty = (fcount == 0);
    assign bus.fifo_dout  = fdout;

    always @(posedge clock) begin
        if (!rst) begin
            fmem.delete();
            fcount <= 0;
            fdout  <= '0;
        end else if (bus.fifo_en) begin
            total++;
            if (!bus.fifo_mode) begin
                if (fcount == D) begin
                    bad++;
                    $display("FAIL fifo_write_when_full: got write at count %0d expected none", fcount);
                end else begin
                    fmem.push_back(bus.fifo_din);
                    fcount <= fcount + 1;
                end
            end else begin
                if (fcount == 0) begin
                    bad++;
                    $display("FAIL fifo_read_when_empty: got read at count 0 expected none");
                end else begin
                    ftmp = fmem.pop_front();
                    fdout  <= ftmp;
                    fcount <= fcount - 1;
                end
            end
        end
    end

    // Scoreboard monitor
    logic [1:0] gnt_hist = 2'b00;
    wexp_t      mon_e;
    logic [W-1:0] mon_d;

    always @(negedge clock) begin
        if (rst) begin
            check("occupancy_vs_fifo", 32'(bus.occupancy), 32'(fcount));
            if (bus.wr_gnt != '0) begin
                check("wr_strobe", 32'({bus.fifo_en, bus.fifo_mode}), 32'h2);
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_wr_gnt: got %b expected none", bus.wr_gnt);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr_gnt", 32'(bus.wr_gnt), 32'(mon_e.gnt));
                    check("fifo_din", 32'(bus.fifo_din), 32'(mon_e.din));
                end
            end
            if (bus.rd_gnt) begin
                check("rd_strobe", 32'({bus.fifo_en, bus.fifo_mode}), 32'h3);
            end
            if (bus.rd_valid) begin
                check("rd_valid_latency", 32'(gnt_hist[1]), 32'h1);
                if (exp_rd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rd_valid: got data %0h expected none", bus.rd_data);
                end else begin
                    mon_d = exp_rd.pop_front();
                    check("rd_data", 32'(bus.rd_data), 32'(mon_d));
                end
            end
            gnt_hist <= {gnt_hist[0], bus.rd_gnt};
        end else begin
            gnt_hist <= 2'b00;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic set_wr(input int i, input logic [W-1:0] d);
        bus.wr_data[i*W +: W] = d;
        bus.wr_req[i] = 1'b1;
    endtask

    task automatic push_wr(input logic [NW-1:0] g, input logic [W-1:0] d);
        wexp_t e;
        e.gnt = g;
        e.din = d;
        exp_wr.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.wr_req = '0;
        bus.rd_req = 1'b0;
        repeat (2) @(negedge clock);
        rst = 1'b1;
    endtask

    // Waits for a write grant, then that requester withdraws its request.
    task automatic wait_wgnt();
        bit got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            if (bus.wr_gnt != '0) begin
                got = 1;
                bus.wr_req = bus.wr_req & ~bus.wr_gnt;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL wr_gnt_timeout: got no grant expected a grant within 40 cycles");
        end
    endtask

    task automatic wait_rgnt();
        bit got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            if (bus.wr_gnt != '0) begin
                total++;
                bad++;
                $display("FAIL op_order: got wr_gnt %b expected rd_gnt first", bus.wr_gnt);
            end
            if (bus.rd_gnt) begin
                got = 1;
                bus.rd_req = 1'b0;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL rd_gnt_timeout: got no grant expected a grant within 40 cycles");
        end
    endtask

    task automatic wait_op(output int op);
        op = 2;
        for (int n = 0; n < 40 && op == 2; n++) begin
            @(negedge clock);
            if (bus.rd_gnt) op = 1;
            else if (bus.wr_gnt != '0) op = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_gnt"},    32'(bus.wr_gnt),    32'h0);
        check({tag, "_rd_gnt"},    32'(bus.rd_gnt),    32'h0);
        check({tag, "_rd_valid"},  32'(bus.rd_valid),  32'h0);
        check({tag, "_rd_data"},   32'(bus.rd_data),   32'h0);
        check({tag, "_fifo_en"},   32'(bus.fifo_en),   32'h0);
        check({tag, "_fifo_mode"}, 32'(bus.fifo_mode), 32'h0);
        check({tag, "_fifo_din"},  32'(bus.fifo_din),  32'h0);
        check({tag, "_occupancy"}, 32'(bus.occupancy), 32'h0);
    endtask

    initial begin
        int op;
        logic [3:0] alt_exp;
        bus.wr_req  = '0;
        bus.wr_data = '0;
        bus.rd_req  = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        rst = 1'b1;

        // 1: single writer
        push_wr(4'b0001, 8'h2A);
        set_wr(0, 8'h2A);
        wait_wgnt();
        @(negedge clock);
        check("single_occ", 32'(bus.occupancy), 32'd1);
        check("single_idle_en", 32'(bus.fifo_en), 32'h0);

        // 2: round-robin fairness
        do_reset();
        push_wr(4'b0001, 8'h10);
        push_wr(4'b0010, 8'h11);
        push_wr(4'b0100, 8'h12);
        push_wr(4'b1000, 8'h13);
        push_wr(4'b0001, 8'h14);
        for (int i = 0; i < NW; i++) set_wr(i, 8'(8'h10 + i));
        for (int n = 1; n <= 5; n++) begin
            wait_wgnt();
            if (n == 1) set_wr(0, 8'h14);
            @(negedge clock);
            check("rr_idle_en", 32'(bus.fifo_en), 32'h0);
            check("rr_occ", 32'(bus.occupancy), 32'(n));
        end

        // 3: full boundary
        for (int i = 0; i < 11; i++) begin
            push_wr(4'b0001, 8'(8'h20 + i));
            set_wr(0, 8'(8'h20 + i));
            wait_wgnt();
        end
        @(negedge clock);
        check("full_occ", 32'(bus.occupancy), 32'd16);
        push_wr(4'b0001, 8'hEE);
        set_wr(0, 8'hEE);
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            check("full_no_en", 32'(bus.fifo_en), 32'h0);
            check("full_no_gnt", 32'(bus.wr_gnt), 32'h0);
        end
        exp_rd.push_back(8'h10);
        bus.rd_req = 1'b1;
        wait_rgnt();
        wait_wgnt();
        @(negedge clock);
        check("full_refill_occ", 32'(bus.occupancy), 32'd16);

        // 4: read/write alternation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_wr(4'b0001, 8'(8'hA0 + i));
            set_wr(0, 8'(8'hA0 + i));
            wait_wgnt();
        end
        exp_rd.push_back(8'hA0);
        exp_rd.push_back(8'hA1);
        push_wr(4'b0010, 8'hB0);
        push_wr(4'b0010, 8'hB1);
        alt_exp = 4'b0101;
        bus.rd_req = 1'b1;
        set_wr(1, 8'hB0);
        for (int n = 0; n < 4; n++) begin
            wait_op(op);
            check("alt_op", 32'(op), 32'(alt_exp[n]));
            if (n == 1) bus.wr_data[W +: W] = 8'hB1;
            if (n == 3 || op == 2) begin
                bus.rd_req = 1'b0;
                bus.wr_req = '0;
            end
        end
        repeat (4) @(negedge clock);
        check("alt_occ", 32'(bus.occupancy), 32'd3);

        // 5: empty read
        do_reset();
        bus.rd_req = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            check("empty_no_rgnt", 32'(bus.rd_gnt), 32'h0);
            check("empty_no_en", 32'(bus.fifo_en), 32'h0);
        end
        push_wr(4'b0100, 8'h07);
        exp_rd.push_back(8'h07);
        set_wr(2, 8'h07);
        wait_wgnt();
        wait_rgnt();
        @(negedge clock);
        check("empty_rd_valid_early", 32'(bus.rd_valid), 32'h0);
        @(negedge clock);
        check("empty_rd_valid", 32'(bus.rd_valid), 32'h1);
        check("empty_rd_data", 32'(bus.rd_data), 32'h07);
        @(negedge clock);
        check("empty_occ", 32'(bus.occupancy), 32'd0);
        check("empty_rd_data_hold", 32'(bus.rd_data), 32'h07);

        // 6: reset during RD_CAP
        push_wr(4'b0010, 8'h55);
        set_wr(1, 8'h55);
        wait_wgnt();
        bus.rd_req = 1'b1;
        wait_rgnt();
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        check_zero("midread");
        rst = 1'b1;
        bus.rd_req = 1'b0;
        push_wr(4'b0001, 8'h61);
        for (int i = 0; i < NW; i++) set_wr(i, 8'(8'h61 + i));
        wait_wgnt();
        bus.wr_req = '0;
        repeat (5) @(negedge clock);

        check("drain_wr", 32'(exp_wr.size()), 32'd0);
        check("drain_rd", 32'(exp_rd.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
